cfg_runtime_ctrl: RTL and testbench

Runtime successor to the static elaboration-time configuration builder. It holds the core's live feature configuration (FP formats, FP vectors, superscalar mode, cache way enables), accepts software reconfiguration requests, and validates them against static capability masks. It quiesces the pipeline through a flush/drain handshake, then derives and atomically applies dependent fields (FLen, vector availability, commit/issue ports, fetch width). It sits beside the CSR file and feeds the frontend, issue, FPU and cache controllers.

---
 rtl/cfg_runtime_pkg.sv | 69 ++++++
 rtl/cfg_runtime_derive.sv | 16 +
 rtl/cfg_runtime_ctrl.sv | 176 +++++++++++++++++
 tb/tb_cfg_runtime_ctrl.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/cfg_runtime_pkg.sv
// Shared definitions for the runtime configuration controller.
// Holds feature-bit positions, the response and FSM encodings, the packed
// derived-configuration record and the function that computes it from a
// feature vector.
package cfg_runtime_pkg;

  localparam int FeatW = 7;

  localparam int FeatRvf     = 0;
  localparam int FeatRvd     = 1;
  localparam int FeatXf16    = 2;
  localparam int FeatXf16alt = 3;
  localparam int FeatXf8     = 4;
  localparam int FeatXfvec   = 5;
  localparam int FeatSuper   = 6;

  typedef enum logic [1:0] {
    RESP_OK      = 2'd0,
    RESP_ILLEGAL = 2'd1,
    RESP_TIMEOUT = 2'd2
  } resp_err_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FLUSH = 2'd1,
    ST_DRAIN = 2'd2,
    ST_APPLY = 2'd3
  } state_e;

  typedef struct packed {
    logic       fp_present;
    logic [6:0] flen;
    logic [3:0] vec;          // {xf8vec, xf16altvec, xf16vec, rvfvec}
    logic [1:0] nr_commit;
    logic [1:0] nr_issue;
    logic [6:0] fetch_width;
  } derived_cfg_t;

  // The non-superscalar commit-port count is a top-level parameter, so it is
  // passed in rather than hard-coded here.
  function automatic derived_cfg_t derive_cfg(input logic [FeatW-1:0] feat,
                                              input logic [1:0] def_nr_commit);
    derived_cfg_t d;
    d = '0;
    d.fp_present = feat[FeatRvf] | feat[FeatRvd] | feat[FeatXf16] |
                   feat[FeatXf16alt] | feat[FeatXf8];
    if (feat[FeatRvd])                          d.flen = 7'd64;
    else if (feat[FeatRvf])                     d.flen = 7'd32;
    else if (feat[FeatXf16] | feat[FeatXf16alt]) d.flen = 7'd16;
    else if (feat[FeatXf8])                     d.flen = 7'd8;
    else                                        d.flen = 7'd1;
    // A vector format needs at least two elements to fit in one FP register.
    d.vec[0] = feat[FeatRvf]     & feat[FeatXfvec] & (d.flen > 7'd32);
    d.vec[1] = feat[FeatXf16]    & feat[FeatXfvec] & (d.flen > 7'd16);
    d.vec[2] = feat[FeatXf16alt] & feat[FeatXfvec] & (d.flen > 7'd16);
    d.vec[3] = feat[FeatXf8]     & feat[FeatXfvec] & (d.flen > 7'd8);
    if (feat[FeatSuper]) begin
      d.nr_commit   = 2'd2;
      d.nr_issue    = 2'd2;
      d.fetch_width = 7'd64;
    end else begin
      d.nr_commit   = def_nr_commit;
      d.nr_issue    = 2'd1;
      d.fetch_width = 7'd32;
    end
    return d;
  endfunction

endpackage

// File: rtl/cfg_runtime_derive.sv
// Combinational derivation of dependent configuration fields.
// Ports:
//   feat : feature vector {superscalar,xfvec,xf8,xf16alt,xf16,rvd,rvf}
//   cfg  : derived configuration record
module cfg_runtime_derive
  import cfg_runtime_pkg::*;
#(
  parameter int DefNrCommitPorts = 2
) (
  input  logic [FeatW-1:0] feat,
  output derived_cfg_t     cfg
);

  assign cfg = derive_cfg(feat, 2'(DefNrCommitPorts));

endmodule

// File: rtl/cfg_runtime_ctrl.sv
// Runtime feature-configuration controller. Accepts reconfiguration requests,
// rejects illegal ones, quiesces the pipeline with a flush/drain handshake and
// then applies the new feature vector and its derived fields in one edge.
// Ports:
//   clk_i, rst_i             : clock, synchronous active-high reset
//   req_valid_i/req_ready_o  : request handshake
//   req_feat_i/iways_i/dways_i : requested features and cache way enables
//   flush_o, drained_i       : pipeline quiesce handshake
//   busy_o                   : reconfiguration in progress
//   resp_valid_o, resp_err_o : completion pulse and status (0 ok,1 illegal,2 timeout)
//   feat_o ... dway_en_o     : active configuration
//
// state | meaning
// IDLE  | waiting for a request; checks legality on acceptance
// FLUSH | one-cycle flush pulse to the pipeline
// DRAIN | waiting for drained_i, bounded by DrainTimeout cycles
// APPLY | load pending configuration into the output registers
module cfg_runtime_ctrl
  import cfg_runtime_pkg::*;
#(
  parameter logic [6:0] CapMask          = 7'h7F,
  parameter logic [6:0] ResetFeat        = 7'h03,
  parameter int         NrIcacheWays     = 4,
  parameter int         NrDcacheWays     = 8,
  parameter int         DefNrCommitPorts = 2,
  parameter int         DrainTimeout     = 1024
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    req_valid_i,
  output logic                    req_ready_o,
  input  logic [6:0]              req_feat_i,
  input  logic [NrIcacheWays-1:0] req_iways_i,
  input  logic [NrDcacheWays-1:0] req_dways_i,
  output logic                    flush_o,
  input  logic                    drained_i,
  output logic                    busy_o,
  output logic                    resp_valid_o,
  output logic [1:0]              resp_err_o,
  output logic [6:0]              feat_o,
  output logic                    fp_present_o,
  output logic [6:0]              flen_o,
  output logic [3:0]              vec_o,
  output logic [1:0]              nr_commit_o,
  output logic [1:0]              nr_issue_o,
  output logic [6:0]              fetch_width_o,
  output logic [NrIcacheWays-1:0] iway_en_o,
  output logic [NrDcacheWays-1:0] dway_en_o
);

  localparam int         CntW    = $clog2(DrainTimeout);
  localparam logic [6:0] RstFeat = ResetFeat & CapMask;
  localparam logic [CntW-1:0] CntLast = CntW'(DrainTimeout - 1);

  state_e                  state_q, state_d;
  logic [CntW-1:0]         cnt_q;
  logic [6:0]              pend_feat_q;
  logic [NrIcacheWays-1:0] pend_iways_q;
  logic [NrDcacheWays-1:0] pend_dways_q;
  logic [6:0]              feat_q;
  derived_cfg_t            cfg_q, rst_cfg, pend_cfg;
  logic [NrIcacheWays-1:0] iway_q;
  logic [NrDcacheWays-1:0] dway_q;
  logic                    resp_valid_q;
  resp_err_e               resp_err_q;

  logic req_illegal, accept, drain_timeout, apply;

  cfg_runtime_derive #(.DefNrCommitPorts(DefNrCommitPorts)) u_derive_rst (
    .feat (RstFeat),
    .cfg  (rst_cfg)
  );

  cfg_runtime_derive #(.DefNrCommitPorts(DefNrCommitPorts)) u_derive_pend (
    .feat (pend_feat_q),
    .cfg  (pend_cfg)
  );

  assign req_illegal = (|(req_feat_i & ~CapMask))
                     | (req_feat_i[FeatRvd] & ~req_feat_i[FeatRvf])
                     | (req_feat_i[FeatXfvec] & ~(|req_feat_i[FeatXf8:FeatRvf]))
                     | (req_iways_i == '0)
                     | (req_dways_i == '0);

  always_comb begin
    state_d       = state_q;
    accept        = 1'b0;
    drain_timeout = 1'b0;
    apply         = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req_valid_i) begin
          accept = 1'b1;
          if (!req_illegal) state_d = ST_FLUSH;
        end
      end
      ST_FLUSH: state_d = ST_DRAIN;
      ST_DRAIN: begin
        // drained_i takes priority over a timeout in the same cycle
        if (drained_i) begin
          state_d = ST_APPLY;
        end else if (cnt_q == CntLast) begin
          state_d       = ST_IDLE;
          drain_timeout = 1'b1;
        end
      end
      ST_APPLY: begin
        state_d = ST_IDLE;
        apply   = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q        <= '0;
      pend_feat_q  <= RstFeat;
      pend_iways_q <= '1;
      pend_dways_q <= '1;
      feat_q       <= RstFeat;
      cfg_q        <= rst_cfg;
      iway_q       <= '1;
      dway_q       <= '1;
      resp_valid_q <= 1'b0;
      resp_err_q   <= RESP_OK;
    end else begin
      resp_valid_q <= 1'b0;
      if (accept) begin
        if (req_illegal) begin
          resp_valid_q <= 1'b1;
          resp_err_q   <= RESP_ILLEGAL;
        end else begin
          pend_feat_q  <= req_feat_i;
          pend_iways_q <= req_iways_i;
          pend_dways_q <= req_dways_i;
        end
      end
      if (state_q == ST_FLUSH)                  cnt_q <= '0;
      else if (state_q == ST_DRAIN && !drained_i) cnt_q <= cnt_q + CntW'(1);
      if (drain_timeout) begin
        resp_valid_q <= 1'b1;
        resp_err_q   <= RESP_TIMEOUT;
      end
      if (apply) begin
        feat_q       <= pend_feat_q;
        cfg_q        <= pend_cfg;
        iway_q       <= pend_iways_q;
        dway_q       <= pend_dways_q;
        resp_valid_q <= 1'b1;
        resp_err_q   <= RESP_OK;
      end
    end
  end

  assign req_ready_o   = (state_q == ST_IDLE);
  assign busy_o        = (state_q != ST_IDLE);
  assign flush_o       = (state_q == ST_FLUSH);
  assign resp_valid_o  = resp_valid_q;
  assign resp_err_o    = resp_err_q;
  assign feat_o        = feat_q;
  assign fp_present_o  = cfg_q.fp_present;
  assign flen_o        = cfg_q.flen;
  assign vec_o         = cfg_q.vec;
  assign nr_commit_o   = cfg_q.nr_commit;
  assign nr_issue_o    = cfg_q.nr_issue;
  assign fetch_width_o = cfg_q.fetch_width;
  assign iway_en_o     = iway_q;
  assign dway_en_o     = dway_q;

endmodule

// File: tb/tb_cfg_runtime_ctrl.sv
module tb_cfg_runtime_ctrl;

  logic       clk_i = 1'b0;
  logic       rst_i = 1'b1;
  logic       req_valid_i = 1'b0;
  logic       req_ready_o;
  logic [6:0] req_feat_i = '0;
  logic [3:0] req_iways_i = '0;
  logic [7:0] req_dways_i = '0;
  logic       flush_o;
  logic       drained_i = 1'b0;
  logic       busy_o;
  logic       resp_valid_o;
  logic [1:0] resp_err_o;
  logic [6:0] feat_o;
  logic       fp_present_o;
  logic [6:0] flen_o;
  logic [3:0] vec_o;
  logic [1:0] nr_commit_o;
  logic [1:0] nr_issue_o;
  logic [6:0] fetch_width_o;
  logic [3:0] iway_en_o;
  logic [7:0] dway_en_o;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [1:0] err;
    logic [6:0] feat;
    logic       fp;
    logic [6:0] flen;
    logic [3:0] vec;
    logic [1:0] commit;
    logic [1:0] issue;
    logic [6:0] fw;
    logic [3:0] iw;
    logic [7:0] dw;
  } exp_t;

  exp_t sb[$];
  exp_t cur;

  cfg_runtime_ctrl #(
    .CapMask(7'h7F), .ResetFeat(7'h03), .NrIcacheWays(4), .NrDcacheWays(8),
    .DefNrCommitPorts(2), .DrainTimeout(16)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i), .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_feat_i(req_feat_i), .req_iways_i(req_iways_i), .req_dways_i(req_dways_i),
    .flush_o(flush_o), .drained_i(drained_i), .busy_o(busy_o),
    .resp_valid_o(resp_valid_o), .resp_err_o(resp_err_o), .feat_o(feat_o),
    .fp_present_o(fp_present_o), .flen_o(flen_o), .vec_o(vec_o),
    .nr_commit_o(nr_commit_o), .nr_issue_o(nr_issue_o), .fetch_width_o(fetch_width_o),
    .iway_en_o(iway_en_o), .dway_en_o(dway_en_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic exp_t mk(input logic [1:0] err, input logic [6:0] feat, input logic fp,
                              input logic [6:0] flen, input logic [3:0] vec,
                              input logic [1:0] commit, input logic [1:0] issue,
                              input logic [6:0] fw, input logic [3:0] iw, input logic [7:0] dw);
    exp_t e;
    e.err = err; e.feat = feat; e.fp = fp; e.flen = flen; e.vec = vec;
    e.commit = commit; e.issue = issue; e.fw = fw; e.iw = iw; e.dw = dw;
    return e;
  endfunction

  // Scoreboard monitor: every response pulse must match the oldest expectation.
  always @(negedge clk_i) begin
    if (resp_valid_o) begin
      if (sb.size() == 0) begin
        chk("unexpected_resp", 32'(resp_err_o), 32'hFFFF_FFFF);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("resp_err",    32'(resp_err_o),    32'(e.err));
        chk("feat",        32'(feat_o),        32'(e.feat));
        chk("fp_present",  32'(fp_present_o),  32'(e.fp));
        chk("flen",        32'(flen_o),        32'(e.flen));
        chk("vec",         32'(vec_o),         32'(e.vec));
        chk("nr_commit",   32'(nr_commit_o),   32'(e.commit));
        chk("nr_issue",    32'(nr_issue_o),    32'(e.issue));
        chk("fetch_width", 32'(fetch_width_o), 32'(e.fw));
        chk("iway_en",     32'(iway_en_o),     32'(e.iw));
        chk("dway_en",     32'(dway_en_o),     32'(e.dw));
      end
    end
  end

  // Issue one request from a negedge, then follow it to its response.
  // drain_at: cycle count (after acceptance) at which drained_i is raised; 0 = never.
  task automatic do_txn(input string name, input logic [6:0] f, input logic [3:0] iw,
                        input logic [7:0] dw, input int drain_at, input int exp_lat,
                        input int exp_flush, input exp_t e);
    int lat, nflush;
    bit seen, changed;
    logic [6:0] feat_b, flen_b;
    logic [3:0] iw_b;
    logic [7:0] dw_b;
    feat_b = feat_o; flen_b = flen_o; iw_b = iway_en_o; dw_b = dway_en_o;
    sb.push_back(e);
    chk({name, "_ready"}, 32'(req_ready_o), 32'd1);
    req_feat_i = f; req_iways_i = iw; req_dways_i = dw; req_valid_i = 1'b1;
    @(posedge clk_i); #1;
    req_valid_i = 1'b0;
    lat = 0; nflush = 0; seen = 0; changed = 0;
    while (!seen && lat < 64) begin
      @(negedge clk_i);
      lat++;
      if (flush_o) nflush++;
      if (lat == drain_at) drained_i = 1'b1;
      if (resp_valid_o) seen = 1;
      else if (feat_o !== feat_b || flen_o !== flen_b || iway_en_o !== iw_b || dway_en_o !== dw_b)
        changed = 1;
    end
    drained_i = 1'b0;
    chk({name, "_seen"},    32'(seen),    32'd1);
    chk({name, "_latency"}, 32'(lat),     32'(exp_lat));
    chk({name, "_flushes"}, 32'(nflush),  32'(exp_flush));
    chk({name, "_early"},   32'(changed), 32'd0);
    chk({name, "_idle"},    32'(busy_o),  32'd0);
  endtask

  task automatic chk_reset(input string name);
    chk({name, "_feat"},  32'(feat_o),        32'h03);
    chk({name, "_fp"},    32'(fp_present_o),  32'd1);
    chk({name, "_flen"},  32'(flen_o),        32'd64);
    chk({name, "_vec"},   32'(vec_o),         32'd0);
    chk({name, "_comm"},  32'(nr_commit_o),   32'd2);
    chk({name, "_iss"},   32'(nr_issue_o),    32'd1);
    chk({name, "_fw"},    32'(fetch_width_o), 32'd32);
    chk({name, "_iway"},  32'(iway_en_o),     32'hF);
    chk({name, "_dway"},  32'(dway_en_o),     32'hFF);
    chk({name, "_busy"},  32'(busy_o),        32'd0);
    chk({name, "_ready"}, 32'(req_ready_o),   32'd1);
    chk({name, "_flush"}, 32'(flush_o),       32'd0);
    chk({name, "_resp"},  32'(resp_valid_o),  32'd0);
  endtask

  initial begin
    repeat (3) @(negedge clk_i);
    rst_i = 1'b0;
    @(negedge clk_i);
    chk_reset("rst");
    cur = mk(2'd0, 7'h03, 1'b1, 7'd64, 4'h0, 2'd2, 2'd1, 7'd32, 4'hF, 8'hFF);

    cur = mk(2'd0, 7'h63, 1'b1, 7'd64, 4'b0001, 2'd2, 2'd2, 7'd64, 4'h3, 8'h0F);
    do_txn("super", 7'h63, 4'h3, 8'h0F, 4, 6, 1, cur);

    begin
      exp_t e;
      e = cur; e.err = 2'd1;
      do_txn("rvd_no_rvf", 7'h02, 4'hF, 8'hFF, 0, 1, 0, e);
      do_txn("vec_no_fp",  7'h20, 4'hF, 8'hFF, 0, 1, 0, e);
      do_txn("iway_zero",  7'h01, 4'h0, 8'hFF, 0, 1, 0, e);
      do_txn("dway_zero",  7'h01, 4'hF, 8'h00, 0, 1, 0, e);
      e.err = 2'd2;
      do_txn("timeout",    7'h05, 4'hF, 8'hFF, 0, 18, 1, e);
    end

    cur = mk(2'd0, 7'h34, 1'b1, 7'd16, 4'b1000, 2'd2, 2'd1, 7'd32, 4'hF, 8'h0F);
    do_txn("f16_vec", 7'h34, 4'hF, 8'h0F, 2, 4, 1, cur);

    cur = mk(2'd0, 7'h3F, 1'b1, 7'd64, 4'hF, 2'd2, 2'd1, 7'd32, 4'h8, 8'h80);
    do_txn("drain_at_tc", 7'h3F, 4'h8, 8'h80, 17, 19, 1, cur);

    cur = mk(2'd0, 7'h00, 1'b0, 7'd1, 4'h0, 2'd2, 2'd1, 7'd32, 4'hF, 8'hFF);
    do_txn("no_fp", 7'h00, 4'hF, 8'hFF, 2, 4, 1, cur);

    // Reset in the middle of DRAIN: no response, back to reset configuration.
    req_feat_i = 7'h41; req_iways_i = 4'h1; req_dways_i = 8'h01; req_valid_i = 1'b1;
    @(posedge clk_i); #1;
    req_valid_i = 1'b0;
    repeat (4) @(negedge clk_i);
    chk("abort_in_drain", 32'(busy_o), 32'd1);
    rst_i = 1'b1;
    repeat (2) @(negedge clk_i);
    chk_reset("mid_rst");
    rst_i = 1'b0;
    cur = mk(2'd0, 7'h50, 1'b1, 7'd8, 4'h0, 2'd2, 2'd2, 7'd64, 4'h1, 8'h01);
    do_txn("after_rst", 7'h50, 4'h1, 8'h01, 2, 4, 1, cur);

    repeat (4) @(negedge clk_i);
    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, errors=%0d", errors);
    $fatal(1);
  end

endmodule
